// File: rtl/multiplication_unit_pkg.sv
// Shared definitions for the sequential multiplier: ALUOp codes decoded
// identically by the ALU and divider, FSM state encodings, and the
// control bundle passed from the FSM to the datapath.
package multiplication_unit_pkg;

  localparam int unsigned ALUOP_W = 5;

  localparam logic [ALUOP_W-1:0] ALU_MULT  = 5'd24;  // signed multiply
  localparam logic [ALUOP_W-1:0] ALU_MULTU = 5'd25;  // unsigned multiply

  typedef enum logic [1:0] {
    MU_IDLE = 2'd0,
    MU_RUN  = 2'd1,
    MU_FIN  = 2'd2
  } mu_state_e;

  // Per-cycle datapath controls produced by the FSM
  typedef struct packed {
    logic load;    // capture operands, clear product
    logic step;    // one shift-add iteration
    logic commit;  // write (optionally negated) product to hi/lo
  } mu_ctrl_t;

  function automatic logic is_mult_op(input logic [ALUOP_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: product/multiplicand/multiplier registers, the
// conditional adder, shifters and the final two's-complement negate.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   ctrl            load/step/commit strobes from the FSM
//   is_signed       operands are two's complement (MULT)
//   a, b            multiplicand / multiplier, used only on load
//   hi, lo          registered product halves, updated on commit
//   mplr_last_c     (early-exit build only) multiplier is zero after this step
module mult_datapath
  import multiplication_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  mu_ctrl_t         ctrl,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_EARLY_EXIT_EN
  ,
  output logic             mplr_last_c
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplr;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    prod_sum;
  logic [PW-1:0]    result;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (is_signed && a[WIDTH-1]) mag_a = WIDTH'(-a);
    if (is_signed && b[WIDTH-1]) mag_b = WIDTH'(-b);
  end

  assign prod_sum = mplr[0] ? PW'(prod + mcand) : prod;
  assign result   = neg ? PW'(-prod) : prod;

`ifdef MULT_EARLY_EXIT_EN
  // No set bits remain once the current LSB is consumed
  assign mplr_last_c = ((mplr >> 1) == '0);
`endif

  // Iteration registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      prod  <= '0;
      mcand <= '0;
      mplr  <= '0;
      neg   <= 1'b0;
    end else if (ctrl.load) begin
      prod  <= '0;
      mcand <= PW'(mag_a);
      mplr  <= mag_b;
      neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (ctrl.step) begin
      prod  <= prod_sum;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

  // Result registers, held between completions
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (ctrl.commit) begin
      hi <= result[PW-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multiplication_unit.sv
// Multi-cycle radix-2 shift-add multiplier for MULT/MULTU, writing HI/LO.
// The CPU stalls on busy and captures hi/lo on the one-cycle done pulse.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as no multiplier bits
// remain (latency 2 + index of the highest set bit of |inB|); results are
// identical to the fixed-latency build (WIDTH+1 cycles).
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   start        request, accepted only in IDLE with a MULT/MULTU ALUOp
//   ALUOp        operation code
//   inA, inB     operands, sampled on the accepting edge
//   flush        abort in-flight operation; blocks a start in IDLE
//   busy         operation in progress
//   done         one-cycle completion pulse
//   hi, lo       product halves, held until the next done
module multiplication_unit
  import multiplication_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  mu_state_e        state;
  mu_state_e        state_next;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             run_last;
  mu_ctrl_t         ctrl;

  assign accept = start && is_mult_op(ALUOp) && !flush;

`ifdef MULT_EARLY_EXIT_EN
  logic mplr_last_c;
  assign run_last = (cnt == CW'(1)) || mplr_last_c;
`else
  assign run_last = (cnt == CW'(1));
`endif

  // State register plus registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MU_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != MU_IDLE);
      done  <= ctrl.commit;
    end
  end

  // Next-state logic; flush wins over completion
  always_comb begin
    state_next = state;
    unique case (state)
      MU_IDLE: if (accept) state_next = MU_RUN;
      MU_RUN: begin
        if (flush)         state_next = MU_IDLE;
        else if (run_last) state_next = MU_FIN;
      end
      MU_FIN:  state_next = MU_IDLE;
      default: state_next = MU_IDLE;
    endcase
  end

  // Datapath strobes
  always_comb begin
    ctrl        = '0;
    ctrl.load   = (state == MU_IDLE) && accept;
    ctrl.step   = (state == MU_RUN) && !flush;
    ctrl.commit = (state == MU_FIN) && !flush;
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (!reset)         cnt <= '0;
    else if (ctrl.load) cnt <= CW'(WIDTH);
    else if (ctrl.step) cnt <= cnt - CW'(1);
  end

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ctrl),
    .is_signed  (ALUOp == ALU_MULT),
    .a          (inA),
    .b          (inB),
    .hi         (hi),
    .lo         (lo)
`ifdef MULT_EARLY_EXIT_EN
    ,
    .mplr_last_c(mplr_last_c)
`endif
  );

endmodule

// File: tb/tb_multiplication_unit.sv
// Scoreboard bench for multiplication_unit: the driver pushes expected
// hi/lo and completion cycle per accepted op; a negedge monitor pops and
// compares on every done pulse.
module tb_multiplication_unit;
  import multiplication_unit_pkg::*;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           flush;
  logic [4:0]     alu_op;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           busy;
  logic           done;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  always #5 clk = ~clk;

  multiplication_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .ALUOp(alu_op),
    .inA  (in_a),
    .inB  (in_b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int ee);
`ifdef MULT_EARLY_EXIT_EN
    return ee;
`else
    return ee * 0 + W + 1;
`endif
  endfunction

  // Monitor: every done must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        e = sb.pop_front();
        n = sb_name.pop_front();
        check({n, "_prod"}, {hi, lo}, e.prod);
        check({n, "_cycle"}, 64'(cyc), 64'(e.cyc));
        check({n, "_busy_at_done"}, 64'(busy), 64'(0));
      end
    end
  end

  // Called at a negedge: present a request and record its expected result
  task automatic issue(input string name, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [63:0] prod, input int ee);
    exp_t e;
    start  = 1'b1;
    alu_op = op;
    in_a   = a;
    in_b   = b;
    e.prod = prod;
    e.cyc  = cyc + 1 + lat_of(ee);
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic wait_done(input string name);
    int n0 = done_cnt;
    for (int i = 0; i < 80 && done_cnt == n0; i++) @(negedge clk);
    if (done_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] prod, input int ee);
    issue(name, op, a, b, prod, ee);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'(1));
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    alu_op = '0;
    in_a   = '0;
    in_b   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Non-multiply code must not start
    start  = 1'b1;
    alu_op = 5'd0;
    in_a   = 32'd5;
    in_b   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", 64'(busy), 64'(0));

    // Directed products
    run_op("multu_max",  ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("mult_m7x3",  ALU_MULT,  32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB, 3);
    run_op("mult_minsq", ALU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
    run_op("multu_5x0",  ALU_MULTU, 32'd5,         32'd0,         64'h0,                   2);
    run_op("multu_5x8",  ALU_MULTU, 32'd5,         32'd8,         64'd40,                  5);
    run_op("mult_0xm5",  ALU_MULT,  32'd0,         32'hFFFF_FFFB, 64'h0,                   4);
    run_op("mult_7xm1",  ALU_MULT,  32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 2);
    run_op("multu_x16",  ALU_MULTU, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 6);
    run_op("mult_minx1", ALU_MULT,  32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 2);
    run_op("mult_maxsq", ALU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 32);
    run_op("multu_2p32", ALU_MULTU, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 3);

    // Set a known hi/lo, then flush an op mid-run
    run_op("pre_flush", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    start  = 1'b1;
    alu_op = ALU_MULTU;
    in_a   = 32'd3;
    in_b   = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_done", 64'(done), 64'(0));
    check("flush_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("post_flush", ALU_MULT, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 3);

    // flush together with start in IDLE: start ignored
    start  = 1'b1;
    flush  = 1'b1;
    alu_op = ALU_MULTU;
    in_a   = 32'd2;
    in_b   = 32'd2;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));

    // start held while busy, then a fresh op accepted in the done cycle
    n0 = done_cnt;
    issue("b2b_a", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 3);
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      alu_op = ALU_MULT;
      in_a   = $urandom;
      in_b   = $urandom;
    end
    check("b2b_saw_done", 64'(done), 64'(1));
    issue("b2b_b", ALU_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 64'd49, 4);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    wait_done("b2b_b");
    repeat (40) @(negedge clk);
    check("b2b_pulses", 64'(done_cnt - n0), 64'(2));

    // Reset mid-run, with start held during reset
    start  = 1'b1;
    alu_op = ALU_MULTU;
    in_a   = 32'hFFFF_FFFF;
    in_b   = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rststart_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("rst_hilo_held", {hi, lo}, 64'(0));
    run_op("after_rst", ALU_MULTU, 32'd5, 32'd8, 64'd40, 5);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
